// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/MDU/LSU per cycle (round-robin or
// fixed priority) and registers the winner onto a single commit port.
module wb_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid_i,
    input  logic        mdu_valid_i,
    input  logic        lsu_valid_i,
    output logic        alu_ready_o,
    output logic        mdu_ready_o,
    output logic        lsu_ready_o,
    input  logic        alu_wena_i,
    input  logic        mdu_wena_i,
    input  logic        lsu_wena_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [4:0]  mdu_waddr_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    input  logic [31:0] mdu_wdata_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        commit_valid_o,
    output logic        commit_wena_o,
    output logic [4:0]  commit_waddr_o,
    output logic [31:0] commit_wdata_o,
    output logic [1:0]  commit_src_o,
    output logic [31:0] commit_cnt_o
);

    // Source indices: 0 ALU, 1 MDU, 2 LSU. Bit 3 is padding so a 2-bit
    // index can never fall outside the vector.
    logic [3:0]  valid_ext;
    logic [2:0]  grant;
    logic [1:0]  sel;
    logic        hs;
    logic [1:0]  ptr_reg;
    logic [1:0]  ptr_next;
    logic [1:0]  cand [3];

    logic        sel_wena;
    logic [4:0]  sel_waddr;
    logic [31:0] sel_wdata;

    logic        commit_valid_reg;
    logic        commit_wena_reg;
    logic [4:0]  commit_waddr_reg;
    logic [31:0] commit_wdata_reg;
    logic [1:0]  commit_src_reg;
    logic [31:0] cnt_reg;

    assign valid_ext = {1'b0, lsu_valid_i, mdu_valid_i, alu_valid_i};

    // Modulo-3 reduction of a small sum (inputs never exceed 4).
    function automatic logic [1:0] wrap3(input logic [2:0] x);
        logic [2:0] r;
        r = (x >= 3'd3) ? (x - 3'd3) : x;
        return r[1:0];
    endfunction

    // Round-robin search order: ptr, ptr+1, ptr+2 (mod 3).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            assign cand[gi] = wrap3({1'b0, ptr_reg} + 3'(gi));
        end
    endgenerate

    // Grant selection; purely a function of valids, pointer and reset.
    always_comb begin
        grant = 3'b000;
        sel   = 2'd0;
        hs    = 1'b0;
        if (!reset) begin
            if (RR_ENABLE != 0) begin
                // Walk from lowest to highest priority so the last hit wins.
                for (int k = 2; k >= 0; k--) begin
                    if (valid_ext[cand[k]]) begin
                        sel = cand[k];
                    end
                end
            end else begin
                if (lsu_valid_i) begin
                    sel = 2'd2;
                end else if (mdu_valid_i) begin
                    sel = 2'd1;
                end else begin
                    sel = 2'd0;
                end
            end
            hs = |valid_ext[2:0];
            if (hs) begin
                grant[sel] = 1'b1;
            end
        end
    end

    assign alu_ready_o = grant[0];
    assign mdu_ready_o = grant[1];
    assign lsu_ready_o = grant[2];

    // Payload of the granted source and the pointer value after its handshake.
    always_comb begin
        sel_wena  = alu_wena_i;
        sel_waddr = alu_waddr_i;
        sel_wdata = alu_wdata_i;
        ptr_next  = 2'd1;
        case (sel)
            2'd1: begin
                sel_wena  = mdu_wena_i;
                sel_waddr = mdu_waddr_i;
                sel_wdata = mdu_wdata_i;
                ptr_next  = 2'd2;
            end
            2'd2: begin
                sel_wena  = lsu_wena_i;
                sel_waddr = lsu_waddr_i;
                sel_wdata = lsu_wdata_i;
                ptr_next  = 2'd0;
            end
            default: begin
                sel_wena  = alu_wena_i;
                sel_waddr = alu_waddr_i;
                sel_wdata = alu_wdata_i;
                ptr_next  = 2'd1;
            end
        endcase
    end

    // Commit register: one-cycle pulse per handshake, payload held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            commit_valid_reg <= 1'b0;
            commit_wena_reg  <= 1'b0;
            commit_waddr_reg <= 5'd0;
            commit_wdata_reg <= 32'd0;
            commit_src_reg   <= 2'd0;
            cnt_reg          <= 32'd0;
            ptr_reg          <= 2'd0;
        end else begin
            commit_valid_reg <= hs;
            if (hs) begin
                commit_wena_reg  <= sel_wena;
                commit_waddr_reg <= sel_waddr;
                commit_wdata_reg <= sel_wdata;
                commit_src_reg   <= sel;
                cnt_reg          <= cnt_reg + 32'd1;
                ptr_reg          <= ptr_next;
            end
        end
    end

    assign commit_valid_o = commit_valid_reg;
    assign commit_wena_o  = commit_wena_reg;
    assign commit_waddr_o = commit_waddr_reg;
    assign commit_wdata_o = commit_wdata_reg;
    assign commit_src_o   = commit_src_reg;
    assign commit_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a round-robin instance driven by a per-cycle vector
// table plus short sequences, and a fixed-priority instance sharing inputs.
module tb_wb_arbiter;

    localparam logic [31:0] ALU_D = 32'hDEAD_BEEF;
    localparam logic [31:0] MDU_D = 32'h1234_5678;
    localparam logic [31:0] LSU_D = 32'hCAFE_F00D;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mdu_valid, lsu_valid;
    logic        alu_wena, mdu_wena, lsu_wena;
    logic [4:0]  alu_waddr, mdu_waddr, lsu_waddr;
    logic [31:0] alu_wdata, mdu_wdata, lsu_wdata;

    logic        alu_ready, mdu_ready, lsu_ready;
    logic        commit_valid, commit_wena;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic [1:0]  commit_src;
    logic [31:0] commit_cnt;

    logic        fp_alu_ready, fp_mdu_ready, fp_lsu_ready;
    logic        fp_commit_valid, fp_commit_wena;
    logic [4:0]  fp_commit_waddr;
    logic [31:0] fp_commit_wdata;
    logic [1:0]  fp_commit_src;
    logic [31:0] fp_commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_arbiter #(.RR_ENABLE(1)) dut (
        .clock(clock), .reset(reset),
        .alu_valid_i(alu_valid), .mdu_valid_i(mdu_valid), .lsu_valid_i(lsu_valid),
        .alu_ready_o(alu_ready), .mdu_ready_o(mdu_ready), .lsu_ready_o(lsu_ready),
        .alu_wena_i(alu_wena), .mdu_wena_i(mdu_wena), .lsu_wena_i(lsu_wena),
        .alu_waddr_i(alu_waddr), .mdu_waddr_i(mdu_waddr), .lsu_waddr_i(lsu_waddr),
        .alu_wdata_i(alu_wdata), .mdu_wdata_i(mdu_wdata), .lsu_wdata_i(lsu_wdata),
        .commit_valid_o(commit_valid), .commit_wena_o(commit_wena),
        .commit_waddr_o(commit_waddr), .commit_wdata_o(commit_wdata),
        .commit_src_o(commit_src), .commit_cnt_o(commit_cnt)
    );

    wb_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clock(clock), .reset(reset),
        .alu_valid_i(alu_valid), .mdu_valid_i(mdu_valid), .lsu_valid_i(lsu_valid),
        .alu_ready_o(fp_alu_ready), .mdu_ready_o(fp_mdu_ready), .lsu_ready_o(fp_lsu_ready),
        .alu_wena_i(alu_wena), .mdu_wena_i(mdu_wena), .lsu_wena_i(lsu_wena),
        .alu_waddr_i(alu_waddr), .mdu_waddr_i(mdu_waddr), .lsu_waddr_i(lsu_waddr),
        .alu_wdata_i(alu_wdata), .mdu_wdata_i(mdu_wdata), .lsu_wdata_i(lsu_wdata),
        .commit_valid_o(fp_commit_valid), .commit_wena_o(fp_commit_wena),
        .commit_waddr_o(fp_commit_waddr), .commit_wdata_o(fp_commit_wdata),
        .commit_src_o(fp_commit_src), .commit_cnt_o(fp_commit_cnt)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  v;      // {lsu, mdu, alu}
        logic [2:0]  rdy;    // expected {lsu, mdu, alu} ready this cycle
        logic        cv;     // expected commit outputs (from previous cycle)
        logic [1:0]  src;
        logic [31:0] cnt;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [2:0] rdy,
                                input logic cv, input logic [1:0] src, input logic [31:0] cnt,
                                input logic [4:0] waddr, input logic [31:0] wdata);
        vec_t r;
        r.rst = rst; r.v = v; r.rdy = rdy; r.cv = cv; r.src = src;
        r.cnt = cnt; r.waddr = waddr; r.wdata = wdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_valid(input logic [2:0] v);
        lsu_valid = v[2];
        mdu_valid = v[1];
        alu_valid = v[0];
    endtask

    // Watchdog: the bench only waits on clock edges, this is a last resort.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vector table, one entry per cycle on the round-robin instance.
        vecs[0]  = mk(1, 3'b111, 3'b000, 0, 0, 0, 0, 32'd0);   // reset gates grants
        vecs[1]  = mk(0, 3'b001, 3'b001, 0, 0, 0, 0, 32'd0);   // ALU alone
        vecs[2]  = mk(0, 3'b000, 3'b000, 1, 0, 1, 5, ALU_D);   // commit, latency 1
        vecs[3]  = mk(0, 3'b000, 3'b000, 0, 0, 1, 5, ALU_D);   // pulse ends, payload holds
        vecs[4]  = mk(1, 3'b111, 3'b000, 0, 0, 1, 5, ALU_D);   // re-reset, ptr back to ALU
        vecs[5]  = mk(0, 3'b111, 3'b001, 0, 0, 0, 0, 32'd0);   // RR: ALU
        vecs[6]  = mk(0, 3'b111, 3'b010, 1, 0, 1, 5, ALU_D);   // RR: MDU
        vecs[7]  = mk(0, 3'b111, 3'b100, 1, 1, 2, 7, MDU_D);   // RR: LSU
        vecs[8]  = mk(0, 3'b111, 3'b001, 1, 2, 3, 9, LSU_D);   // RR: ALU
        vecs[9]  = mk(0, 3'b111, 3'b010, 1, 0, 4, 5, ALU_D);   // RR: MDU
        vecs[10] = mk(0, 3'b111, 3'b100, 1, 1, 5, 7, MDU_D);   // RR: LSU
        vecs[11] = mk(0, 3'b000, 3'b000, 1, 2, 6, 9, LSU_D);   // cnt=6
        vecs[12] = mk(0, 3'b110, 3'b010, 0, 2, 6, 9, LSU_D);   // ptr=0, ALU idle -> MDU
        vecs[13] = mk(0, 3'b011, 3'b001, 1, 1, 7, 7, MDU_D);   // ptr=2, LSU idle -> ALU
        vecs[14] = mk(0, 3'b000, 3'b000, 1, 0, 8, 5, ALU_D);

        reset = 1'b1;
        drive_valid(3'b000);
        alu_wena = 1'b1; alu_waddr = 5'd5; alu_wdata = ALU_D;
        mdu_wena = 1'b1; mdu_waddr = 5'd7; mdu_wdata = MDU_D;
        lsu_wena = 1'b1; lsu_waddr = 5'd9; lsu_wdata = LSU_D;
        repeat (2) @(posedge clock);
        @(negedge clock);

        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst;
            drive_valid(vecs[i].v);
            #1;
            $display("vec %0d: rst=%0b v=%03b rdy=%03b cv=%0b src=%0d cnt=%0d",
                     i, reset, vecs[i].v, {lsu_ready, mdu_ready, alu_ready},
                     commit_valid, commit_src, commit_cnt);
            chk($sformatf("vec%0d_ready", i), {29'd0, lsu_ready, mdu_ready, alu_ready}, {29'd0, vecs[i].rdy});
            chk($sformatf("vec%0d_cvalid", i), {31'd0, commit_valid}, {31'd0, vecs[i].cv});
            chk($sformatf("vec%0d_src", i), {30'd0, commit_src}, {30'd0, vecs[i].src});
            chk($sformatf("vec%0d_cnt", i), commit_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_waddr", i), {27'd0, commit_waddr}, {27'd0, vecs[i].waddr});
            chk($sformatf("vec%0d_wdata", i), commit_wdata, vecs[i].wdata);
            @(negedge clock);
        end

        // MDU request with wena=0, waddr=0 passes through; ptr=1 here.
        mdu_wena = 1'b0; mdu_waddr = 5'd0; mdu_wdata = 32'h0000_0055;
        drive_valid(3'b010);
        #1;
        chk("nowena_ready", {29'd0, lsu_ready, mdu_ready, alu_ready}, 32'b010);
        @(negedge clock);
        drive_valid(3'b000);
        #1;
        $display("nowena: cv=%0b wena=%0b waddr=%0d cnt=%0d", commit_valid, commit_wena, commit_waddr, commit_cnt);
        chk("nowena_cvalid", {31'd0, commit_valid}, 32'd1);
        chk("nowena_wena", {31'd0, commit_wena}, 32'd0);
        chk("nowena_waddr", {27'd0, commit_waddr}, 32'd0);
        chk("nowena_wdata", commit_wdata, 32'h0000_0055);
        chk("nowena_src", {30'd0, commit_src}, 32'd1);
        chk("nowena_cnt", commit_cnt, 32'd9);
        mdu_wena = 1'b1; mdu_waddr = 5'd7; mdu_wdata = MDU_D;

        // Reset in the cycle after a handshake; ptr=2 here, ALU alone wins.
        drive_valid(3'b001);
        #1;
        chk("rstmid_ready", {29'd0, lsu_ready, mdu_ready, alu_ready}, 32'b001);
        @(negedge clock);
        drive_valid(3'b000);
        reset = 1'b1;
        #1;
        chk("rstmid_cvalid_pre", {31'd0, commit_valid}, 32'd1);
        chk("rstmid_cnt_pre", commit_cnt, 32'd10);
        @(negedge clock);
        reset = 1'b0;
        drive_valid(3'b111);
        #1;
        $display("rstmid: cv=%0b cnt=%0d rdy=%03b", commit_valid, commit_cnt, {lsu_ready, mdu_ready, alu_ready});
        chk("rstmid_cvalid_post", {31'd0, commit_valid}, 32'd0);
        chk("rstmid_cnt_post", commit_cnt, 32'd0);
        chk("rstmid_ptr_alu", {29'd0, lsu_ready, mdu_ready, alu_ready}, 32'b001);
        @(negedge clock);
        drive_valid(3'b000);
        #1;
        chk("rstmid_src", {30'd0, commit_src}, 32'd0);
        chk("rstmid_cnt1", commit_cnt, 32'd1);

        // Counter wrap: preload 0xFFFFFFFF, then one LSU commit.
        force dut.cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_reg;
        drive_valid(3'b100);
        #1;
        chk("wrap_ready", {29'd0, lsu_ready, mdu_ready, alu_ready}, 32'b100);
        @(negedge clock);
        drive_valid(3'b000);
        #1;
        $display("wrap: cv=%0b src=%0d cnt=0x%08h", commit_valid, commit_src, commit_cnt);
        chk("wrap_cvalid", {31'd0, commit_valid}, 32'd1);
        chk("wrap_src", {30'd0, commit_src}, 32'd2);
        chk("wrap_cnt", commit_cnt, 32'd0);

        // Fixed priority instance: LSU, then MDU, then ALU as each drops.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive_valid(3'b111);
        #1;
        chk("fp_ready1", {29'd0, fp_lsu_ready, fp_mdu_ready, fp_alu_ready}, 32'b100);
        @(negedge clock);
        drive_valid(3'b011);
        #1;
        $display("fp1: cv=%0b src=%0d rdy=%03b", fp_commit_valid, fp_commit_src, {fp_lsu_ready, fp_mdu_ready, fp_alu_ready});
        chk("fp_src1", {30'd0, fp_commit_src}, 32'd2);
        chk("fp_waddr1", {27'd0, fp_commit_waddr}, 32'd9);
        chk("fp_cnt1", fp_commit_cnt, 32'd1);
        chk("fp_ready2", {29'd0, fp_lsu_ready, fp_mdu_ready, fp_alu_ready}, 32'b010);
        @(negedge clock);
        drive_valid(3'b001);
        #1;
        chk("fp_src2", {30'd0, fp_commit_src}, 32'd1);
        chk("fp_cnt2", fp_commit_cnt, 32'd2);
        chk("fp_ready3", {29'd0, fp_lsu_ready, fp_mdu_ready, fp_alu_ready}, 32'b001);
        @(negedge clock);
        drive_valid(3'b000);
        #1;
        chk("fp_cvalid3", {31'd0, fp_commit_valid}, 32'd1);
        chk("fp_src3", {30'd0, fp_commit_src}, 32'd0);
        chk("fp_wena3", {31'd0, fp_commit_wena}, 32'd1);
        chk("fp_wdata3", fp_commit_wdata, ALU_D);
        chk("fp_cnt3", fp_commit_cnt, 32'd3);
        @(negedge clock);
        #1;
        chk("fp_idle", {31'd0, fp_commit_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
